// File: rtl/uart_tx_x.sv
// rtl/uart_tx_x.sv - UART transmitter with TX FIFO, 5-8 data bits, parity, 1/2 stop bits.
// Optional line break generation is enabled by defining UART_TX_X_BREAK_EN.
module uart_tx_x #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   baud_div,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity,
    input  logic                          stop2,
    input  logic                          break_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          tx_o
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int OSW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP1,
        S_STOP2
`ifdef UART_TX_X_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    logic [15:0]    div_cnt;
    logic           tick;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic [7:0]     head;
    logic [7:0]     head_mask;
    logic           head_par;

    state_t         state;
    logic [OSW-1:0] os_cnt;
    logic [7:0]     sh;
    logic [2:0]     bit_cnt;
    logic [1:0]     db_q;
    logic           par_en_q;
    logic           par_bit_q;
    logic           stop2_q;
    logic           tx_q;
    logic           bit_end;
    logic           frame_end;
    logic           idle_slot;
    logic           brk_go;

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (div_cnt == 16'd0)
            div_cnt <= baud_div;
        else
            div_cnt <= div_cnt - 16'd1;
    end
    assign tick = (div_cnt == 16'd0);

    assign ready_o      = (count < CW'(FIFO_DEPTH));
    assign push         = valid_i && ready_o;
    assign fifo_count_o = count;
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

`ifdef UART_TX_X_BREAK_EN
    logic brk_mark;
`else
    logic unused_break;
    assign unused_break = break_i;
`endif

    // idle_slot is every tick where a new frame may begin: plain IDLE ticks
    // and the final tick of a frame, so queued bytes follow with no gap.
    always_comb begin
        bit_end   = tick && (os_cnt == OSW'(OVERSAMPLE - 1));
        frame_end = bit_end && ((state == S_STOP1 && !stop2_q) || state == S_STOP2);
`ifdef UART_TX_X_BREAK_EN
        if (bit_end && state == S_BREAK && brk_mark)
            frame_end = 1'b1;
`endif
        idle_slot = (tick && state == S_IDLE) || frame_end;
`ifdef UART_TX_X_BREAK_EN
        brk_go    = idle_slot && break_i;
`else
        brk_go    = 1'b0;
`endif
        pop       = idle_slot && !brk_go && (count != '0);
        head_mask = 8'hFF >> (2'd3 - data_bits);
        head_par  = (^(head & head_mask)) ^ (parity == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            os_cnt    <= '0;
            sh        <= '0;
            bit_cnt   <= '0;
            db_q      <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
`ifdef UART_TX_X_BREAK_EN
            brk_mark  <= 1'b0;
`endif
        end else if (idle_slot) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
`ifdef UART_TX_X_BREAK_EN
            brk_mark <= 1'b0;
            if (brk_go) begin
                state <= S_BREAK;
                tx_q  <= 1'b0;
            end else
`endif
            if (pop) begin
                state     <= S_START;
                tx_q      <= 1'b0;
                sh        <= head;
                db_q      <= data_bits;
                par_en_q  <= (parity == 2'd1) || (parity == 2'd2);
                par_bit_q <= head_par;
                stop2_q   <= stop2;
            end else begin
                state <= S_IDLE;
                tx_q  <= 1'b1;
            end
        end else if (tick && state != S_IDLE) begin
`ifdef UART_TX_X_BREAK_EN
            // Break holds the line low until released, then one mark bit.
            if (state == S_BREAK && !brk_mark) begin
                if (!break_i) begin
                    brk_mark <= 1'b1;
                    tx_q     <= 1'b1;
                end
            end else
`endif
            if (!bit_end) begin
                os_cnt <= os_cnt + OSW'(1);
            end else begin
                os_cnt <= '0;
                case (state)
                    S_START: begin
                        state <= S_DATA;
                        tx_q  <= sh[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == 3'(db_q) + 3'd4) begin
                            state <= par_en_q ? S_PAR : S_STOP1;
                            tx_q  <= par_en_q ? par_bit_q : 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sh      <= sh >> 1;
                            tx_q    <= sh[1];
                        end
                    end
                    S_PAR: begin
                        state <= S_STOP1;
                        tx_q  <= 1'b1;
                    end
                    S_STOP1: begin
                        state <= S_STOP2;
                        tx_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o = (state != S_IDLE);
    assign tx_o   = tx_q;
endmodule

// File: tb/tb_uart_tx_x.sv
// tb/tb_uart_tx_x.sv - directed self-checking bench for uart_tx_x.
module tb_uart_tx_x;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  data_bits;
    logic [1:0]  parity;
    logic        stop2;
    logic        break_i;
    logic [2:0]  fifo_count_o;
    logic        busy_o;
    logic        tx_o;

    int checks = 0;
    int errors = 0;

    uart_tx_x #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_bits(data_bits),
        .parity(parity), .stop2(stop2), .break_i(break_i),
        .fifo_count_o(fifo_count_o), .busy_o(busy_o), .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  db;
        logic [1:0]  par;
        logic        s2;
        logic [15:0] div;
        int          nbits;
        logic [11:0] exp;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] fbytes [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_low(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s start bit timeout actual=none expected=low", nm);
    endtask

    // Entered on the negedge of the first cycle of bit 0; returns on the
    // negedge just after the last bit. Each bit must hold for exactly cpb cycles.
    task automatic check_bits(input logic [11:0] exp, input int n, input int cpb, input string nm);
        for (int k = 0; k < n; k++) begin
            int bad = 0;
            for (int c = 0; c < cpb; c++) begin
                if (tx_o !== exp[k]) bad++;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d_badcycles", nm, k), bad, 0);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic run_vec(input int i);
        bit ok;
        baud_div  = vecs[i].div;
        data_bits = vecs[i].db;
        parity    = vecs[i].par;
        stop2     = vecs[i].s2;
        @(negedge clk);
        push_byte(vecs[i].data);
        wait_low($sformatf("vec%0d", i), ok);
        if (ok) begin
            data_bits = ~vecs[i].db;
            parity    = ~vecs[i].par;
            stop2     = ~vecs[i].s2;
            check_bits(vecs[i].exp, vecs[i].nbits, (int'(vecs[i].div) + 1) * 16,
                       $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_idle_tx", i), tx_o, 1);
            chk($sformatf("vec%0d_idle_busy", i), busy_o, 0);
        end
    endtask

    initial begin
        bit ok;
        int low;

        vecs[0] = '{8'h55, 2'd3, 2'd0, 1'b0, 16'd0, 10, 12'h2AA};
        vecs[1] = '{8'h55, 2'd3, 2'd1, 1'b0, 16'd0, 11, 12'h4AA};
        vecs[2] = '{8'h41, 2'd2, 2'd2, 1'b1, 16'd0, 11, 12'h782};
        vecs[3] = '{8'hF3, 2'd0, 2'd3, 1'b0, 16'd2,  7, 12'h066};
        vecs[4] = '{8'h2C, 2'd1, 2'd2, 1'b0, 16'd0,  9, 12'h158};
        vecs[5] = '{8'hA7, 2'd3, 2'd1, 1'b1, 16'd0, 12, 12'hF4E};
        fbytes  = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hA5};

        rst = 1'b1; baud_div = '0; data_i = '0; valid_i = 1'b0;
        data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0; break_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_o, 1);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", fifo_count_o, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Depth-4 FIFO fed continuously: six back-to-back 8N1 frames.
        baud_div = 16'd0; data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        fork
            begin
                int  idx = 0;
                bit  drop_seen = 1'b0;
                bit  r;
                valid_i = 1'b1;
                data_i  = fbytes[0];
                for (int cyc = 0; cyc < 2000 && idx < 6; cyc++) begin
                    r = ready_o;
                    if (!r && !drop_seen) begin
                        drop_seen = 1'b1;
                        chk("fifo_drop_after", idx, 5);
                        chk("fifo_full_count", fifo_count_o, 4);
                    end
                    @(negedge clk);
                    if (r) idx++;
                    if (idx < 6) data_i = fbytes[idx];
                end
                valid_i = 1'b0;
                chk("fifo_all_accepted", idx, 6);
                chk("fifo_drop_seen", drop_seen, 1);
            end
            begin
                bit fok;
                wait_low("fifo", fok);
                if (fok)
                    for (int f = 0; f < 6; f++)
                        check_bits({1'b1, fbytes[f], 1'b0}, 10, 16, $sformatf("fifo_f%0d", f));
            end
        join
        chk("fifo_end_tx", tx_o, 1);
        chk("fifo_end_busy", busy_o, 0);
        chk("fifo_end_count", fifo_count_o, 0);

        // Reset in the middle of DATA with a second byte still queued.
        @(negedge clk);
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_low("rstmid", ok);
        if (ok) begin
            repeat (16 * 3 + 5) @(negedge clk);
            chk("rstmid_pre_tx", tx_o, 0);
            chk("rstmid_pre_busy", busy_o, 1);
            rst = 1'b1;
            @(negedge clk);
            chk("rstmid_tx", tx_o, 1);
            chk("rstmid_count", fifo_count_o, 0);
            chk("rstmid_busy", busy_o, 0);
            chk("rstmid_ready", ready_o, 1);
            rst = 1'b0;
            low = 0;
            repeat (400) begin
                @(negedge clk);
                if (tx_o !== 1'b1) low++;
            end
            chk("rstmid_no_frame", low, 0);
        end

`ifdef UART_TX_X_BREAK_EN
        // 50 bit-times of break with two bytes queued behind it.
        baud_div = 16'd0; data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        break_i = 1'b1;
        wait_low("brk", ok);
        if (ok) begin
            low = 0;
            for (int i = 0; i < 800; i++) begin
                if (tx_o === 1'b0) low++;
                if (i == 1) begin valid_i = 1'b1; data_i = 8'h3C; end
                if (i == 2) data_i = 8'hC3;
                if (i == 3) valid_i = 1'b0;
                if (i == 400) begin
                    chk("brk_no_pop", fifo_count_o, 2);
                    chk("brk_busy", busy_o, 1);
                end
                if (i == 799) break_i = 1'b0;
                @(negedge clk);
            end
            chk("brk_low_cycles", low, 800);
            check_bits(12'h001, 1, 16, "brk_mark");
            check_bits({1'b1, 8'h3C, 1'b0}, 10, 16, "brk_f0");
            check_bits({1'b1, 8'hC3, 1'b0}, 10, 16, "brk_f1");
            chk("brk_end_busy", busy_o, 0);
        end
`else
        // Without break support, break_i must not disturb a normal frame.
        break_i = 1'b1;
        run_vec(0);
        break_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
